// File: rtl/cordic_pkg.sv
// Shared angle units and CORDIC constants for the vectoring and sin/cos paths.
// 4096 angle units make one full turn.
package cordic_pkg;
    localparam int DATA_W     = 12;
    localparam int XY_W       = 15;
    localparam int Z_W        = 14;
    localparam int ANGLE_90   = 1024;
    localparam int ANGLE_180  = 2048;
    localparam int ANGLE_FULL = 4096;
    localparam int MAG_K_DEF  = 1243;
    localparam logic [DATA_W-1:0] ADC_OFFSET = 12'h800;

    typedef enum logic [1:0] {S_IDLE, S_ROT, S_SCALE} state_e;

    // atan(2^-i) in angle units
    function automatic logic signed [Z_W-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 14'sd512;
            4'd1:    atan_lut = 14'sd302;
            4'd2:    atan_lut = 14'sd160;
            4'd3:    atan_lut = 14'sd81;
            4'd4:    atan_lut = 14'sd41;
            4'd5:    atan_lut = 14'sd20;
            4'd6:    atan_lut = 14'sd10;
            4'd7:    atan_lut = 14'sd5;
            4'd8:    atan_lut = 14'sd3;
            4'd9:    atan_lut = 14'sd1;
            4'd10:   atan_lut = 14'sd1;
            default: atan_lut = 14'sd0;
        endcase
    endfunction
endpackage

// File: rtl/get_pre_rot.sv
// Quadrant fold: maps the left half-plane onto the right by a 180 deg turn so
// the micro-rotations only ever have to cover +/-90 deg.
module get_pre_rot
    import cordic_pkg::*;
(
    input  logic signed [XY_W-1:0] xs,
    input  logic signed [XY_W-1:0] ys,
    output logic signed [XY_W-1:0] x0,
    output logic signed [XY_W-1:0] y0,
    output logic signed [Z_W-1:0]  z0,
    output logic                   is_zero
);
    always_comb begin
        is_zero = (xs == '0) && (ys == '0);
        if (xs[XY_W-1]) begin
            x0 = -xs;
            y0 = -ys;
            z0 = Z_W'(ANGLE_180);
        end else begin
            x0 = xs;
            y0 = ys;
            z0 = '0;
        end
    end
endmodule

// File: rtl/cordic_vec_adc.sv
// Iterative vectoring CORDIC: offset-binary (x, y) in, phase and
// gain-compensated magnitude out, one result per accepted start.
module cordic_vec_adc
    import cordic_pkg::*;
#(
    parameter int ITER  = 9,
    parameter int MAG_K = MAG_K_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] angle_out,
    output logic [DATA_W-1:0] mag_out,
    output logic              zero_flag
);
    localparam int PROD_W = XY_W + 13;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic signed [XY_W-1:0]  x_q, x_d, y_q, y_d;
    logic signed [Z_W-1:0]   z_q, z_d;
    logic                    zero_q, zero_d;
    logic [DATA_W-1:0]       angle_q, angle_d, mag_q, mag_d;
    logic                    zf_q, zf_d, done_q, done_d;

    logic signed [XY_W-1:0]  xs_c, ys_c, x0, y0, xsh, ysh;
    logic signed [Z_W-1:0]   z0, atan_i;
    logic                    is_zero;
    logic signed [PROD_W-1:0] prod, mag_s;
    logic [DATA_W-1:0]       mag_sat;

    assign xs_c = $signed({3'b000, x_in}) - $signed({3'b000, ADC_OFFSET});
    assign ys_c = $signed({3'b000, y_in}) - $signed({3'b000, ADC_OFFSET});

    get_pre_rot u_pre_rot (
        .xs(xs_c), .ys(ys_c), .x0(x0), .y0(y0), .z0(z0), .is_zero(is_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
            zf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ROT;
            S_ROT:   if (cnt_q == 4'(ITER - 1)) state_d = S_SCALE;
            S_SCALE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        xsh    = x_q >>> cnt_q;
        ysh    = y_q >>> cnt_q;
        atan_i = atan_lut(cnt_q);
        prod   = PROD_W'(x_q) * PROD_W'(MAG_K);
        mag_s  = prod >>> 11;
        // x stays non-negative after the fold; the low clamp is only a guard
        if (mag_s < 0)                mag_sat = '0;
        else if (mag_s > 4095)        mag_sat = 12'hFFF;
        else                          mag_sat = mag_s[DATA_W-1:0];

        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        zf_d    = zf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                x_d    = x0;
                y_d    = y0;
                z_d    = z0;
                zero_d = is_zero;
                cnt_d  = '0;
            end
            S_ROT: begin
                if (!y_q[XY_W-1]) begin
                    x_d = x_q + ysh;
                    y_d = y_q - xsh;
                    z_d = z_q + atan_i;
                end else begin
                    x_d = x_q - ysh;
                    y_d = y_q + xsh;
                    z_d = z_q - atan_i;
                end
                cnt_d = cnt_q + 4'd1;
            end
            S_SCALE: begin
                done_d = 1'b1;
                if (zero_q) begin
                    angle_d = '0;
                    mag_d   = '0;
                    zf_d    = 1'b1;
                end else begin
                    angle_d = z_q[DATA_W-1:0];
                    mag_d   = mag_sat;
                    zf_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    assign done      = done_q;
    assign angle_out = angle_q;
    assign mag_out   = mag_q;
    assign zero_flag = zf_q;
endmodule

// File: tb/tb_cordic_vec_adc.sv
// Directed and random checks of the vectoring CORDIC against an integer
// model of the algorithm plus analytic tolerance targets.
module tb_cordic_vec_adc;
    localparam int ITER = 9;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, zero_flag;
    logic [11:0] x_in, y_in, angle_out, mag_out;
    int tests = 0, fails = 0;
    int m_ang, m_mag, m_zf;

    cordic_vec_adc #(.ITER(ITER), .MAG_K(1243)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
        .busy(busy), .done(done), .angle_out(angle_out), .mag_out(mag_out),
        .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    function automatic void model(input int xi, input int yi,
                                  output int ang, output int mag, output int zf);
        int at[12];
        int xs, ys, x, y, z, xn;
        at = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0};
        xs = xi - 2048;
        ys = yi - 2048;
        if (xs < 0) begin x = -xs; y = -ys; z = 2048; end
        else        begin x = xs;  y = ys;  z = 0;    end
        for (int i = 0; i < ITER; i++) begin
            if (y >= 0) begin xn = x + (y >>> i); y = y - (x >>> i); z = z + at[i]; end
            else        begin xn = x - (y >>> i); y = y + (x >>> i); z = z - at[i]; end
            x = xn;
        end
        ang = z & 4095;
        mag = (x * 1243) >>> 11;
        if (mag > 4095) mag = 4095;
        if (mag < 0)    mag = 0;
        zf = 0;
        if (xs == 0 && ys == 0) begin ang = 0; mag = 0; zf = 1; end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp,
                           input int tol, input bit circ);
        int d;
        d = obs - exp;
        if (circ) d = ((d + 6144) % 4096) - 2048;
        tests++;
        assert (d <= tol && d >= -tol) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // one full transaction: latency, exact result, single-cycle done
    task automatic run(input string tag, input logic [11:0] xv, input logic [11:0] yv);
        int n;
        @(negedge clk);
        x_in = xv; y_in = yv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 30);
        chk({tag, "_latency"}, n, ITER + 1);
        model(xv, yv, m_ang, m_mag, m_zf);
        chk({tag, "_angle"}, angle_out, m_ang);
        chk({tag, "_mag"}, mag_out, m_mag);
        chk({tag, "_zf"}, zero_flag, m_zf);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {busy, done}, 0);
    endtask

    initial begin
        int ndone, dk, a0, m0;
        logic [11:0] xr, yr;
        rst = 1'b1; start = 1'b0; x_in = 12'h800; y_in = 12'h800;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, zero_flag, angle_out, mag_out}, 0);
        @(negedge clk) rst = 1'b0;

        run("east", 12'hBE8, 12'h800);
        chk_tol("east_ang_tol", angle_out, 0, 3, 1);
        chk_tol("east_mag_tol", mag_out, 1000, 8, 0);
        run("diag", 12'hBE8, 12'hBE8);
        chk_tol("diag_ang_tol", angle_out, 512, 3, 1);
        chk_tol("diag_mag_tol", mag_out, 1414, 10, 0);
        run("north", 12'h800, 12'hBE8);
        chk_tol("north_ang_tol", angle_out, 1024, 3, 1);
        chk_tol("north_mag_tol", mag_out, 1000, 8, 0);
        run("west", 12'h418, 12'h800);
        chk_tol("west_ang_tol", angle_out, 2048, 3, 1);
        chk_tol("west_mag_tol", mag_out, 1000, 8, 0);
        run("south", 12'h800, 12'h418);
        chk_tol("south_ang_tol", angle_out, 3072, 3, 1);
        chk_tol("south_mag_tol", mag_out, 1000, 8, 0);
        run("zero", 12'h800, 12'h800);
        chk("zero_all", {zero_flag, angle_out, mag_out}, {1'b1, 24'd0});
        run("after_zero", 12'h900, 12'h7F0);
        chk("after_zero_zf", zero_flag, 0);
        run("corner", 12'h000, 12'h000);
        chk_tol("corner_ang_tol", angle_out, 2560, 3, 1);
        chk_tol("corner_mag_tol", mag_out, 2896, 16, 0);
        run("corner_ff", 12'hFFF, 12'h000);
        run("corner_0f", 12'h000, 12'hFFF);

        for (int k = 0; k < 16; k++) begin
            xr = 12'($urandom_range(0, 4095));
            yr = 12'($urandom_range(0, 4095));
            run($sformatf("rnd%0d", k), xr, yr);
        end

        // extra starts during a run are dropped; inputs are sampled once
        @(negedge clk);
        x_in = 12'hA00; y_in = 12'h650; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; dk = 0; a0 = 0; m0 = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2 || k == 4) begin
                start = 1'b1; x_in = 12'h123; y_in = 12'hEDC;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin ndone++; dk = k; a0 = angle_out; m0 = mag_out; end
        end
        start = 1'b0;
        model(12'hA00, 12'h650, m_ang, m_mag, m_zf);
        chk("repulse_ndone", ndone, 1);
        chk("repulse_latency", dk, ITER + 1);
        chk("repulse_angle", a0, m_ang);
        chk("repulse_mag", m0, m_mag);

        // async reset mid-ROT aborts with no done
        @(negedge clk);
        x_in = 12'hC00; y_in = 12'hB00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("rst_mid_outs", {busy, done, zero_flag, angle_out, mag_out}, 0);
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("rst_mid_no_done", ndone, 0);
        run("post_rst", 12'hC00, 12'hB00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
